multi_phase_traffic_ctrl: RTL and testbench

MULTI_PHASE_TRAFFIC_CTRL -- requirements
Module: multi_phase_traffic_ctrl

---
 rtl/tlc_pkg.sv | 34 +++
 rtl/tlc_flasher.sv | 27 ++
 rtl/multi_phase_traffic_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_multi_phase_traffic_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared state and lamp-triplet encoding for the multi-phase traffic controller.
// The PED state exists only when TLC_PED_EN is defined.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
`ifdef TLC_PED_EN
    ST_PED     = 3'd3,
`endif
    ST_EMERG   = 3'd4,
    ST_FLASH   = 3'd5
  } tlc_state_e;

  // Bit order {green, yellow, red}: exactly one bit set per approach outside FLASH.
  typedef enum logic [2:0] {
    LAMP_OFF = 3'b000,
    LAMP_RED = 3'b001,
    LAMP_YEL = 3'b010,
    LAMP_GRN = 3'b100
  } lamp_e;

  function automatic lamp_e lamp_for(input tlc_state_e st, input logic served);
    lamp_e l;
    l = LAMP_RED;
    if (served) begin
      if (st == ST_GREEN || st == ST_EMERG) l = LAMP_GRN;
      else if (st == ST_YELLOW)             l = LAMP_YEL;
    end
    return l;
  endfunction

endpackage

// File: rtl/tlc_flasher.sv
// Flash divider: while enabled, pulses toggle_c on the last cycle of every
// FLASH_HALF-cycle half period; counter rests at zero when disabled.
module tlc_flasher #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic toggle_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign toggle_c = en_i && (cnt_q == CNT_W'(FLASH_HALF - 1));

  always_comb begin
    cnt_d = '0;
    if (en_i && !toggle_c) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Multi-approach traffic controller with actuated green, transit extension,
// emergency preemption and fault flash. Define TLC_PED_EN for the pedestrian phase.
module multi_phase_traffic_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned N_APPR     = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned GREEN_MAX  = 10,
  parameter int unsigned YELLOW_T   = 2,
  parameter int unsigned ALLRED_T   = 1,
  parameter int unsigned PED_T      = 5,
  parameter int unsigned EXT_STEP   = 3,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_APPR-1:0]         veh_req,
  input  logic [N_APPR-1:0]         ped_req,
  input  logic [N_APPR-1:0]         emerg,
  input  logic [N_APPR-1:0]         transit,
  input  logic                      fault,
  output logic [N_APPR-1:0]         green,
  output logic [N_APPR-1:0]         yellow,
  output logic [N_APPR-1:0]         red,
  output logic                      walk,
  output logic [$clog2(N_APPR)-1:0] phase_idx
);

  localparam int unsigned    IDX_W     = $clog2(N_APPR);
  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] GEXT_M1 = CNT_W'(GREEN_MAX + EXT_STEP - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);

  tlc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  phase_q, phase_d;
  logic              ext_q, ext_d;
  logic              home_q, home_d;
  logic [N_APPR-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
  logic [IDX_W-1:0]  rr_next, emerg_tgt;
  logic [N_APPR-1:0] own_oh;
  logic              others_req;
  logic [CNT_W-1:0]  green_end;
  logic              flash_tog;
  logic              flash_en;

`ifdef TLC_PED_EN
  logic [N_APPR-1:0] ped_lat_q, ped_lat_d;
  logic              ped_done_q, ped_done_d;
  logic              walk_q, walk_d;
`else
  logic unused_ped;
  assign unused_ped = ^ped_req;
`endif

  assign flash_en = (state_q == ST_FLASH);

  tlc_flasher #(
    .CNT_W      (CNT_W),
    .FLASH_HALF (FLASH_HALF)
  ) u_flasher (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (flash_en),
    .toggle_c (flash_tog)
  );

  assign own_oh     = N_APPR'(1) << phase_q;
  assign others_req = |(veh_req & ~own_oh);
  assign green_end  = ext_q ? GEXT_M1 : GMAX_M1;

  // Round-robin search starting after the current phase; lowest emergency index wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    rr_next   = (phase_q == IDX_W'(N_APPR - 1)) ? '0 : phase_q + IDX_W'(1);
    emerg_tgt = '0;
    for (int k = 1; k <= int'(N_APPR); k++) begin
      cand = IDX_W'((int'(phase_q) + k) % int'(N_APPR));
      if (!found && veh_req[cand]) begin
        rr_next = cand;
        found   = 1'b1;
      end
    end
    for (int i = int'(N_APPR) - 1; i >= 0; i--) begin
      if (emerg[i]) emerg_tgt = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    ext_d   = ext_q;
    home_d  = home_q;
`ifdef TLC_PED_EN
    ped_lat_d  = ped_lat_q | ped_req;
    ped_done_d = ped_done_q;
`endif
    if (fault) begin
      state_d = ST_FLASH;
    end else begin
      unique case (state_q)
        ST_ALL_RED: begin
          if (cnt_q == AR_M1) begin
            if (|emerg) begin
              state_d = ST_EMERG;
              phase_d = emerg_tgt;
            end else if (home_q) begin
              state_d = ST_GREEN;
              phase_d = '0;
            end
`ifdef TLC_PED_EN
            else if (|ped_lat_q && !ped_done_q) begin
              state_d = ST_PED;
            end
`endif
            else begin
              state_d = ST_GREEN;
              phase_d = rr_next;
            end
          end
        end
        ST_GREEN: begin
          if (|emerg) begin
            state_d = (emerg_tgt == phase_q) ? ST_EMERG : ST_YELLOW;
          end else if (cnt_q >= GMIN_M1 && !veh_req[phase_q] && others_req) begin
            state_d = ST_YELLOW;
          end else if (cnt_q == green_end) begin
            if (transit[phase_q] && !ext_q) ext_d = 1'b1;
            else                            state_d = ST_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (cnt_q == YEL_M1) state_d = ST_ALL_RED;
        end
`ifdef TLC_PED_EN
        ST_PED: begin
          if (|emerg || cnt_q == CNT_W'(PED_T - 1)) begin
            state_d    = ST_ALL_RED;
            ped_done_d = 1'b1;
          end
        end
`endif
        ST_EMERG: begin
          if (!emerg[phase_q]) state_d = ST_YELLOW;
        end
        ST_FLASH: begin
          state_d = ST_ALL_RED;
          home_d  = 1'b1;
        end
        default: state_d = ST_ALL_RED;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
    if (state_d == ST_GREEN && state_q != ST_GREEN) begin
      ext_d  = 1'b0;
      home_d = 1'b0;
`ifdef TLC_PED_EN
      ped_done_d = 1'b0;
`endif
    end
`ifdef TLC_PED_EN
    if (state_d == ST_PED && state_q != ST_PED) ped_lat_d = '0;
`endif
  end

  // Lamps are decoded from the next state so they line up with state_q.
  always_comb begin
    logic [2:0] lb;
    lb       = LAMP_RED;
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    for (int i = 0; i < int'(N_APPR); i++) begin
      lb          = lamp_for(state_d, phase_d == IDX_W'(i));
      green_d[i]  = lb[2];
      yellow_d[i] = lb[1];
      red_d[i]    = lb[0];
    end
    if (state_d == ST_FLASH) begin
      green_d  = '0;
      yellow_d = '0;
      if (state_q != ST_FLASH) red_d = '1;
      else if (flash_tog)      red_d = ~red_q;
      else                     red_d = red_q;
    end
`ifdef TLC_PED_EN
    walk_d = (state_d == ST_PED);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ALL_RED;
      cnt_q    <= '0;
      phase_q  <= IDX_W'(N_APPR - 1);
      ext_q    <= 1'b0;
      home_q   <= 1'b1;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
`ifdef TLC_PED_EN
      ped_lat_q  <= '0;
      ped_done_q <= 1'b0;
      walk_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      ext_q    <= ext_d;
      home_q   <= home_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
`ifdef TLC_PED_EN
      ped_lat_q  <= ped_lat_d;
      ped_done_q <= ped_done_d;
      walk_q     <= walk_d;
`endif
    end
  end

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign red       = red_q;
  assign phase_idx = phase_q;
`ifdef TLC_PED_EN
  assign walk = walk_q;
`else
  assign walk = 1'b0;
`endif

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Scoreboard bench for multi_phase_traffic_ctrl: directed scenarios push per-cycle
// expected lamp/phase snapshots; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_multi_phase_traffic_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] veh_req = '0, ped_req = '0, emerg = '0, transit = '0;
  logic       fault = 1'b0;
  logic [3:0] green, yellow, red;
  logic       walk;
  logic [1:0] phase_idx;

  always #5 clk = ~clk;

  multi_phase_traffic_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .veh_req   (veh_req),
    .ped_req   (ped_req),
    .emerg     (emerg),
    .transit   (transit),
    .fault     (fault),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .walk      (walk),
    .phase_idx (phase_idx)
  );

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic       w;
    logic [1:0] ph;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   cursor = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the snapshot scheduled for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s cyc %0d: expectation never sampled", e.nm, e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      n_tests++;
      if ({green, yellow, red, walk, phase_idx} !== {e.g, e.y, e.r, e.w, e.ph}) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got g=%b y=%b r=%b walk=%b ph=%0d, want g=%b y=%b r=%b walk=%b ph=%0d",
                 e.nm, cyc, green, yellow, red, walk, phase_idx, e.g, e.y, e.r, e.w, e.ph);
      end
    end
  end

  // Lamp exclusivity invariant: one lamp per approach, at most one approach not red.
  always @(negedge clk) begin
    if (reset_n) begin
      n_tests++;
      if ((green & yellow) !== 4'b0000) begin
        n_fail++;
        $display("FAIL lamp_excl cyc %0d: green=%b yellow=%b overlap", cyc, green, yellow);
      end
      if (((green | yellow) & red) !== 4'b0000) begin
        n_fail++;
        $display("FAIL lamp_red cyc %0d: g=%b y=%b r=%b", cyc, green, yellow, red);
      end
      if ($countones(green | yellow) > 1) begin
        n_fail++;
        $display("FAIL one_served cyc %0d: g=%b y=%b", cyc, green, yellow);
      end
    end
  end

  task automatic seg(input string nm, input logic [3:0] g, input logic [3:0] y,
                     input logic [3:0] r, input logic w, input logic [1:0] ph, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = cursor; e.g = g; e.y = y; e.r = r; e.w = w; e.ph = ph; e.nm = nm;
      sb.push_back(e);
      cursor++;
    end
  endtask

  task automatic ar(input string nm, input logic [1:0] ph, input int n);
    seg(nm, 4'b0000, 4'b0000, 4'b1111, 1'b0, ph, n);
  endtask

  task automatic gr(input string nm, input int i, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    seg(nm, oh, 4'b0000, ~oh, 1'b0, 2'(i), n);
  endtask

  task automatic yl(input string nm, input int i, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    seg(nm, 4'b0000, oh, ~oh, 1'b0, 2'(i), n);
  endtask

  task automatic fl(input string nm, input logic on, input logic [1:0] ph, input int n);
    seg(nm, 4'b0000, 4'b0000, on ? 4'b1111 : 4'b0000, 1'b0, ph, n);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    at_cyc(cursor);
  endtask

  // Async reset mid-phase: lamps must drop to all red within the same cycle.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    veh_req = '0; ped_req = '0; emerg = '0; transit = '0; fault = 1'b0;
    cursor = cyc;
    ar("reset_async", 2'd3, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cursor = cyc;
  endtask

  initial begin
    int b;

    // No requests: full-length green, then plain rotation to approach 1.
    do_reset();
    ar("t1_init_ar", 2'd3, 1);
    gr("t1_g0", 0, 10);
    yl("t1_y0", 0, 2);
    ar("t1_ar", 2'd0, 1);
    gr("t1_g1", 1, 2);
    wait_done();

    // Gap-out after minimum green; approach 2 chosen over 1.
    do_reset();
    veh_req = 4'b0100;
    ar("t2_init_ar", 2'd3, 1);
    gr("t2_g0_min", 0, 4);
    yl("t2_y0", 0, 2);
    ar("t2_ar", 2'd0, 1);
    gr("t2_g2", 2, 3);
    wait_done();

    // Transit extension applied once: 13 cycles total.
    do_reset();
    transit = 4'b0001;
    ar("t3_init_ar", 2'd3, 1);
    gr("t3_g0_ext", 0, 13);
    yl("t3_y0", 0, 2);
    ar("t3_ar", 2'd0, 1);
    gr("t3_g1", 1, 1);
    wait_done();

    // Pedestrian pulse during approach 1 green.
    do_reset();
    b = cursor;
    ar("t4_init_ar", 2'd3, 1);
    gr("t4_g0", 0, 10);
    yl("t4_y0", 0, 2);
    ar("t4_ar0", 2'd0, 1);
    gr("t4_g1", 1, 10);
    yl("t4_y1", 1, 2);
    ar("t4_ar1", 2'd1, 1);
`ifdef TLC_PED_EN
    seg("t4_ped", 4'b0000, 4'b0000, 4'b1111, 1'b1, 2'd1, 5);
    ar("t4_ar_post_ped", 2'd1, 1);
`endif
    gr("t4_g2", 2, 2);
    at_cyc(b + 15);
    ped_req = 4'b1000;
    at_cyc(b + 16);
    ped_req = 4'b0000;
    wait_done();

    // Emergency for approach 1 (with 3 also set) during approach 0 green.
    do_reset();
    b = cursor;
    ar("t5_init_ar", 2'd3, 1);
    gr("t5_g0", 0, 2);
    yl("t5_y0", 0, 2);
    ar("t5_ar0", 2'd0, 1);
    gr("t5_emerg_g1", 1, 7);
    yl("t5_y1", 1, 2);
    ar("t5_ar1", 2'd1, 1);
    gr("t5_g2", 2, 2);
    at_cyc(b + 2);
    emerg = 4'b1010;
    at_cyc(b + 12);
    emerg = 4'b0000;
    wait_done();

    // Fault during yellow: flash 4 on / 4 off, then all red and approach 0.
    do_reset();
    b = cursor;
    ar("t6_init_ar", 2'd3, 1);
    gr("t6_g0", 0, 10);
    yl("t6_y0", 0, 1);
    fl("t6_flash_on1", 1'b1, 2'd0, 4);
    fl("t6_flash_off1", 1'b0, 2'd0, 4);
    fl("t6_flash_on2", 1'b1, 2'd0, 4);
    fl("t6_flash_off2", 1'b0, 2'd0, 2);
    ar("t6_ar", 2'd0, 1);
    gr("t6_g0_after", 0, 2);
    at_cyc(b + 11);
    fault = 1'b1;
    at_cyc(b + 25);
    fault = 1'b0;
    wait_done();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) $display("PASS");
    else             $display("FAIL: %0d mismatches", n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
